// File: rtl/ob_pkg.sv
// Shared order-table command/response types and arbiter state encoding,
// used by both the ask-side and bid-side table arbiters.
package ob_pkg;

    localparam int UID_W   = 32;
    localparam int PRICE_W = 16;
    localparam int QTY_W   = 16;

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_CANCEL = 2'd1,
        OP_PEEK   = 2'd2,
        OP_POP    = 2'd3
    } ob_tbl_op_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_EMPTY    = 2'd1,
        ST_NOTFOUND = 2'd2,
        ST_TIMEOUT  = 2'd3
    } ob_tbl_status_t;

    typedef struct packed {
        ob_tbl_op_t         op;
        logic [UID_W-1:0]   uid;
        logic [PRICE_W-1:0] price;
        logic [QTY_W-1:0]   qty;
    } ob_tbl_cmd_t;

    typedef struct packed {
        ob_tbl_status_t     status;
        logic [UID_W-1:0]   uid;
        logic [PRICE_W-1:0] price;
        logic [QTY_W-1:0]   qty;
    } ob_tbl_rsp_t;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_WAIT  = 2'd2;
    localparam logic [1:0] ARB_RESP  = 2'd3;

endpackage

// File: rtl/ob_table_arb_if.sv
// Bundle of the two requester ports and the single order-table port.
// Every *_vld/*_rdy pair transfers when both are high at a rising clk edge; a
// raised vld keeps its payload stable until that edge. tbl_rsp_vld is the only
// exception: a one-cycle pulse with no ready.
interface ob_table_arb_if;
    import ob_pkg::*;

    logic        cmd0_vld;
    ob_tbl_cmd_t cmd0;
    logic        cmd0_rdy;
    logic        cmd1_vld;
    ob_tbl_cmd_t cmd1;
    logic        cmd1_rdy;

    logic        rsp0_vld;
    ob_tbl_rsp_t rsp0;
    logic        rsp0_rdy;
    logic        rsp1_vld;
    ob_tbl_rsp_t rsp1;
    logic        rsp1_rdy;

    logic        tbl_cmd_vld;
    ob_tbl_cmd_t tbl_cmd;
    logic        tbl_cmd_rdy;
    logic        tbl_rsp_vld;
    ob_tbl_rsp_t tbl_rsp;

    modport slave (
        input  cmd0_vld, cmd0, cmd1_vld, cmd1, rsp0_rdy, rsp1_rdy,
               tbl_cmd_rdy, tbl_rsp_vld, tbl_rsp,
        output cmd0_rdy, cmd1_rdy, rsp0_vld, rsp0, rsp1_vld, rsp1,
               tbl_cmd_vld, tbl_cmd
    );

    modport master (
        output cmd0_vld, cmd0, cmd1_vld, cmd1, rsp0_rdy, rsp1_rdy,
               tbl_cmd_rdy, tbl_rsp_vld, tbl_rsp,
        input  cmd0_rdy, cmd1_rdy, rsp0_vld, rsp0, rsp1_vld, rsp1,
               tbl_cmd_vld, tbl_cmd
    );

endinterface

// File: rtl/ob_rr_arb2.sv
// Two-way round-robin picker: requester 1 wins when alone or when ptr favours it.
module ob_rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[1] && (!req[0] || ptr)) begin
            gnt = 2'b10;
        end else if (req[0]) begin
            gnt = 2'b01;
        end
    end

endmodule

// File: rtl/ob_table_arb.sv
// Shares the ask-side order table between command ingress (0) and the match
// engine (1): one transaction in flight, response routed to its owner, timeout.
module ob_table_arb
    import ob_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    ob_table_arb_if.slave        bus,
    output logic                 busy,
    output logic                 err_spurious,
    output logic [1:0]           o_dbg_state,
    output logic                 o_dbg_ptr
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic             r_ptr;
    logic             r_owner;
    logic [TMR_W-1:0] r_timer;
    logic             r_err;
    ob_tbl_cmd_t      r_cmd;
    ob_tbl_rsp_t      r_rsp;

    logic [1:0] w_gnt;
    logic       w_live;
    logic       w_idle;
    logic       w_resp;
    logic       w_rsp_hs;

    ob_rr_arb2 u_rr (
        .req ({bus.cmd1_vld, bus.cmd0_vld}),
        .ptr (r_ptr),
        .gnt (w_gnt)
    );

    // Outputs are forced quiet while rst is held, even before the state register clears.
    assign w_live = !rst;
    assign w_idle = w_live && (r_state == ARB_IDLE);
    assign w_resp = w_live && (r_state == ARB_RESP);

    assign bus.cmd0_rdy    = w_idle && w_gnt[0];
    assign bus.cmd1_rdy    = w_idle && w_gnt[1];
    assign bus.tbl_cmd_vld = w_live && (r_state == ARB_ISSUE);
    assign bus.tbl_cmd     = r_cmd;
    assign bus.rsp0_vld    = w_resp && !r_owner;
    assign bus.rsp1_vld    = w_resp && r_owner;
    assign bus.rsp0        = r_rsp;
    assign bus.rsp1        = r_rsp;

    assign w_rsp_hs = (bus.rsp0_vld && bus.rsp0_rdy) || (bus.rsp1_vld && bus.rsp1_rdy);

    assign busy         = w_live && (r_state != ARB_IDLE);
    assign err_spurious = r_err;
    assign o_dbg_state  = r_state;
    assign o_dbg_ptr    = r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_timer <= '0;
            r_err   <= 1'b0;
            r_cmd   <= '0;
            r_rsp   <= '0;
        end else begin
            // Late answers after a timeout or reset land here rather than being delivered.
            if (bus.tbl_rsp_vld && (r_state != ARB_WAIT)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ARB_IDLE: begin
                    if (|w_gnt) begin
                        r_cmd   <= w_gnt[1] ? bus.cmd1 : bus.cmd0;
                        r_owner <= w_gnt[1];
                        r_state <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (bus.tbl_cmd_rdy) begin
                        r_timer <= '0;
                        r_state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (bus.tbl_rsp_vld) begin
                        r_rsp   <= bus.tbl_rsp;
                        r_state <= ARB_RESP;
                    end else if (r_timer == TMR_LAST) begin
                        r_rsp.status <= ST_TIMEOUT;
                        r_rsp.uid    <= r_cmd.uid;
                        r_rsp.price  <= '0;
                        r_rsp.qty    <= '0;
                        r_state      <= ARB_RESP;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ARB_RESP: begin
                    if (w_rsp_hs) begin
                        r_ptr   <= ~r_owner;
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ob_table_arb.sv
// Directed bench for ob_table_arb: grant order, latency, backpressure, timeout,
// timeout/response race and reset mid-transaction.
module tb_ob_table_arb;
    import ob_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic       err_spurious;
    logic [1:0] dbg_state;
    logic       dbg_ptr;

    ob_table_arb_if bus();

    ob_table_arb #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .err_spurious (err_spurious),
        .o_dbg_state  (dbg_state),
        .o_dbg_ptr    (dbg_ptr)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [35:0] exp_q[$];
    logic [1:0]  exp_g[$];
    bit          track_g = 1'b0;
    int          r1_cnt = 0;
    int          r1_base;
    logic [35:0] obs;
    int          n;
    ob_tbl_cmd_t cap;
    ob_tbl_cmd_t c1, c3, c4, c5, c6;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ob_tbl_cmd_t mk_cmd(input ob_tbl_op_t op, input logic [31:0] uid,
                                           input logic [15:0] price, input logic [15:0] qty);
        ob_tbl_cmd_t c;
        c.op = op; c.uid = uid; c.price = price; c.qty = qty;
        return c;
    endfunction

    function automatic ob_tbl_rsp_t mk_rsp(input ob_tbl_status_t st, input logic [31:0] uid,
                                           input logic [15:0] price, input logic [15:0] qty);
        ob_tbl_rsp_t r;
        r.status = st; r.uid = uid; r.price = price; r.qty = qty;
        return r;
    endfunction

    // {rsp1_vld, rsp0_vld, status, uid} as seen at a response handshake
    function automatic logic [35:0] sb_key(input logic owner, input ob_tbl_status_t st,
                                           input logic [31:0] uid);
        return {owner, ~owner, st, uid};
    endfunction

    // Monitor samples late in the cycle, well clear of both clock edges.
    always @(negedge clk) begin
        #4;
        if (bus.rsp1_vld) r1_cnt++;
        if ((bus.rsp0_vld && bus.rsp0_rdy) || (bus.rsp1_vld && bus.rsp1_rdy)) begin
            obs = {bus.rsp1_vld, bus.rsp0_vld,
                   bus.rsp0_vld ? bus.rsp0.status : bus.rsp1.status,
                   bus.rsp0_vld ? bus.rsp0.uid : bus.rsp1.uid};
            if (exp_q.size() == 0) check("sb_unexpected", obs, 36'd0);
            else                   check("sb_rsp", obs, exp_q.pop_front());
        end
        if (track_g && ((bus.cmd0_vld && bus.cmd0_rdy) || (bus.cmd1_vld && bus.cmd1_rdy))) begin
            if (exp_g.size() == 0) check("grant_unexpected", {bus.cmd1_rdy, bus.cmd0_rdy}, 2'b00);
            else                   check("grant_order", {bus.cmd1_rdy, bus.cmd0_rdy}, exp_g.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.cmd0_vld    = 1'b0;
        bus.cmd0        = '0;
        bus.cmd1_vld    = 1'b0;
        bus.cmd1        = '0;
        bus.rsp0_rdy    = 1'b0;
        bus.rsp1_rdy    = 1'b0;
        bus.tbl_cmd_rdy = 1'b0;
        bus.tbl_rsp_vld = 1'b0;
        bus.tbl_rsp     = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state, with both requesters already asking
        rst = 1'b1;
        idle_inputs();
        bus.cmd0_vld = 1'b1;
        bus.cmd1_vld = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_rdy", {bus.cmd1_rdy, bus.cmd0_rdy}, 2'b00);
        check("rst_vld", {bus.tbl_cmd_vld, bus.rsp1_vld, bus.rsp0_vld}, 3'b000);
        check("rst_err", err_spurious, 1'b0);
        check("rst_state", dbg_state, ARB_IDLE);
        check("rst_ptr", dbg_ptr, 1'b0);
        bus.cmd0_vld = 1'b0;
        bus.cmd1_vld = 1'b0;
        rst = 1'b0;

        // Single request with latency checks
        r1_base = r1_cnt;
        c1 = mk_cmd(OP_INSERT, 32'd5, 16'd100, 16'd10);
        @(negedge clk);
        bus.cmd0 = c1; bus.cmd0_vld = 1'b1; bus.tbl_cmd_rdy = 1'b1;
        #1;
        check("t1_grant", {bus.cmd1_rdy, bus.cmd0_rdy}, 2'b01);
        @(negedge clk);
        bus.cmd0_vld = 1'b0;
        #1;
        check("t1_issue_vld", bus.tbl_cmd_vld, 1'b1);
        check("t1_issue_cmd", bus.tbl_cmd, c1);
        check("t1_busy", busy, 1'b1);
        @(negedge clk);
        #1;
        check("t1_wait", {bus.tbl_cmd_vld, dbg_state}, {1'b0, ARB_WAIT});
        @(negedge clk);
        bus.tbl_rsp_vld = 1'b1; bus.tbl_rsp = mk_rsp(ST_OK, 32'd5, 16'd100, 16'd10);
        #1;
        check("t1_no_early_rsp", bus.rsp0_vld, 1'b0);
        @(negedge clk);
        bus.tbl_rsp_vld = 1'b0; bus.rsp0_rdy = 1'b1;
        exp_q.push_back(sb_key(1'b0, ST_OK, 32'd5));
        #1;
        check("t1_rsp_vld", bus.rsp0_vld, 1'b1);
        check("t1_rsp_status", bus.rsp0.status, ST_OK);
        check("t1_rsp_uid", bus.rsp0.uid, 32'd5);
        @(negedge clk);
        bus.rsp0_rdy = 1'b0; bus.tbl_cmd_rdy = 1'b0;
        #1;
        check("t1_idle", busy, 1'b0);
        check("t1_no_rsp1", r1_cnt - r1_base, 0);

        // Contention: both requesters valid from reset for four transactions
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        bus.cmd0 = mk_cmd(OP_INSERT, 32'd10, 16'd200, 16'd1);
        bus.cmd1 = mk_cmd(OP_PEEK, 32'd20, 16'd0, 16'd0);
        bus.cmd0_vld = 1'b1; bus.cmd1_vld = 1'b1;
        bus.tbl_cmd_rdy = 1'b1; bus.rsp0_rdy = 1'b1; bus.rsp1_rdy = 1'b1;
        exp_g = {2'b01, 2'b10, 2'b01, 2'b10};
        exp_q.push_back(sb_key(1'b0, ST_OK, 32'd10));
        exp_q.push_back(sb_key(1'b1, ST_OK, 32'd20));
        exp_q.push_back(sb_key(1'b0, ST_OK, 32'd10));
        exp_q.push_back(sb_key(1'b1, ST_OK, 32'd20));
        track_g = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                #1;
                n++;
            end while (!bus.tbl_cmd_vld && n < 20);
            check("t2_issue_seen", bus.tbl_cmd_vld, 1'b1);
            cap = bus.tbl_cmd;
            if (k == 3) begin
                bus.cmd0_vld = 1'b0; bus.cmd1_vld = 1'b0;
            end
            @(negedge clk);
            bus.tbl_rsp_vld = 1'b1; bus.tbl_rsp = mk_rsp(ST_OK, cap.uid, cap.price, cap.qty);
            @(negedge clk);
            bus.tbl_rsp_vld = 1'b0;
        end
        @(negedge clk);
        #1;
        track_g = 1'b0;
        check("t2_idle", busy, 1'b0);
        check("t2_grants_left", exp_g.size(), 0);
        check("t2_rsp_left", exp_q.size(), 0);
        check("t2_ptr", dbg_ptr, 1'b0);
        idle_inputs();

        // Backpressure on table command, then on the response
        c3 = mk_cmd(OP_CANCEL, 32'd77, 16'd300, 16'd4);
        @(negedge clk);
        bus.cmd0 = c3; bus.cmd0_vld = 1'b1;
        bus.cmd1 = mk_cmd(OP_POP, 32'd88, 16'd0, 16'd0); bus.cmd1_vld = 1'b1;
        #1;
        check("t3_grant", {bus.cmd1_rdy, bus.cmd0_rdy}, 2'b01);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.cmd0_vld = 1'b0;
            #1;
            check("t3_cmd_hold", {bus.tbl_cmd_vld, bus.tbl_cmd}, {1'b1, c3});
            check("t3_no_grant_issue", {busy, bus.cmd1_rdy}, 2'b10);
        end
        @(negedge clk);
        bus.tbl_cmd_rdy = 1'b1;
        #1;
        check("t3_cmd_at_hs", {bus.tbl_cmd_vld, bus.tbl_cmd}, {1'b1, c3});
        @(negedge clk);
        bus.tbl_cmd_rdy = 1'b0;
        bus.tbl_rsp_vld = 1'b1; bus.tbl_rsp = mk_rsp(ST_OK, 32'd77, 16'd300, 16'd4);
        #1;
        check("t3_wait", {bus.cmd1_rdy, dbg_state}, {1'b0, ARB_WAIT});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.tbl_rsp_vld = 1'b0;
            #1;
            check("t3_rsp_hold", {bus.rsp0_vld, bus.rsp0}, {1'b1, mk_rsp(ST_OK, 32'd77, 16'd300, 16'd4)});
            check("t3_no_grant_resp", bus.cmd1_rdy, 1'b0);
        end
        @(negedge clk);
        bus.rsp0_rdy = 1'b1;
        exp_q.push_back(sb_key(1'b0, ST_OK, 32'd77));
        #1;
        check("t3_rsp_at_hs", bus.rsp0_vld, 1'b1);
        @(negedge clk);
        bus.cmd1_vld = 1'b0; bus.rsp0_rdy = 1'b0;
        #1;
        check("t3_idle", busy, 1'b0);
        check("t3_ptr", dbg_ptr, 1'b1);

        // Timeout: table accepts but never answers
        c4 = mk_cmd(OP_POP, 32'd33, 16'd0, 16'd0);
        @(negedge clk);
        bus.cmd1 = c4; bus.cmd1_vld = 1'b1; bus.tbl_cmd_rdy = 1'b1; bus.rsp1_rdy = 1'b0;
        #1;
        check("t4_grant", {bus.cmd1_rdy, bus.cmd0_rdy}, 2'b10);
        @(negedge clk);
        bus.cmd1_vld = 1'b0;
        #1;
        check("t4_issue", bus.tbl_cmd_vld, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.tbl_cmd_rdy = 1'b0;
            #1;
            check("t4_wait", {bus.rsp1_vld, dbg_state}, {1'b0, ARB_WAIT});
        end
        @(negedge clk);
        bus.rsp1_rdy = 1'b1;
        exp_q.push_back(sb_key(1'b1, ST_TIMEOUT, 32'd33));
        #1;
        check("t4_tmo_vld", {bus.rsp1_vld, bus.rsp0_vld}, 2'b10);
        check("t4_tmo_rsp", bus.rsp1, mk_rsp(ST_TIMEOUT, 32'd33, 16'd0, 16'd0));
        check("t4_err_before", err_spurious, 1'b0);
        @(negedge clk);
        bus.rsp1_rdy = 1'b0;
        #1;
        check("t4_idle", busy, 1'b0);
        @(negedge clk);
        bus.tbl_rsp_vld = 1'b1; bus.tbl_rsp = mk_rsp(ST_OK, 32'd33, 16'd7, 16'd7);
        @(negedge clk);
        bus.tbl_rsp_vld = 1'b0;
        #1;
        check("t4_err_set", err_spurious, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("t4_err_sticky", {err_spurious, busy, bus.rsp1_vld}, 3'b100);

        // Race: response arrives in the timer expiry cycle
        do_reset();
        c5 = mk_cmd(OP_INSERT, 32'd44, 16'd50, 16'd6);
        @(negedge clk);
        bus.cmd0 = c5; bus.cmd0_vld = 1'b1; bus.tbl_cmd_rdy = 1'b1;
        #1;
        check("t5_grant", {bus.cmd1_rdy, bus.cmd0_rdy}, 2'b01);
        @(negedge clk);
        bus.cmd0_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.tbl_cmd_rdy = 1'b0;
            if (i == 7) begin
                bus.tbl_rsp_vld = 1'b1; bus.tbl_rsp = mk_rsp(ST_OK, 32'd44, 16'd50, 16'd6);
            end
        end
        @(negedge clk);
        bus.tbl_rsp_vld = 1'b0; bus.rsp0_rdy = 1'b1;
        exp_q.push_back(sb_key(1'b0, ST_OK, 32'd44));
        #1;
        check("t5_rsp", bus.rsp0, mk_rsp(ST_OK, 32'd44, 16'd50, 16'd6));
        check("t5_vld", {bus.rsp1_vld, bus.rsp0_vld}, 2'b01);
        check("t5_err", err_spurious, 1'b0);
        @(negedge clk);
        bus.rsp0_rdy = 1'b0;
        #1;
        check("t5_idle", {busy, err_spurious}, 2'b00);

        // Reset in WAIT, then a lone requester 1 request
        c6 = mk_cmd(OP_PEEK, 32'd21, 16'd0, 16'd0);
        @(negedge clk);
        bus.cmd0 = mk_cmd(OP_INSERT, 32'd9, 16'd1, 16'd1); bus.cmd0_vld = 1'b1; bus.tbl_cmd_rdy = 1'b1;
        #1;
        check("t6_grant0", {bus.cmd1_rdy, bus.cmd0_rdy}, 2'b01);
        @(negedge clk);
        bus.cmd0_vld = 1'b0;
        @(negedge clk);
        bus.tbl_cmd_rdy = 1'b0;
        #1;
        check("t6_in_wait", dbg_state, ARB_WAIT);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.cmd1 = c6; bus.cmd1_vld = 1'b1; bus.tbl_cmd_rdy = 1'b1;
        #1;
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_vld", {bus.tbl_cmd_vld, bus.rsp1_vld, bus.rsp0_vld}, 3'b000);
        check("t6_rst_ptr", {dbg_ptr, dbg_state}, {1'b0, ARB_IDLE});
        check("t6_grant1", {bus.cmd1_rdy, bus.cmd0_rdy}, 2'b10);
        @(negedge clk);
        bus.cmd1_vld = 1'b0;
        #1;
        check("t6_issue", {bus.tbl_cmd_vld, bus.tbl_cmd}, {1'b1, c6});
        @(negedge clk);
        bus.tbl_cmd_rdy = 1'b0;
        bus.tbl_rsp_vld = 1'b1; bus.tbl_rsp = mk_rsp(ST_EMPTY, 32'd21, 16'd0, 16'd0);
        @(negedge clk);
        bus.tbl_rsp_vld = 1'b0; bus.rsp1_rdy = 1'b1;
        exp_q.push_back(sb_key(1'b1, ST_EMPTY, 32'd21));
        #1;
        check("t6_rsp", {bus.rsp1_vld, bus.rsp1.status}, {1'b1, ST_EMPTY});
        @(negedge clk);
        bus.rsp1_rdy = 1'b0;
        #1;
        check("t6_idle", {busy, err_spurious}, 2'b00);

        // ---------------- final report ----------------
        repeat (2) @(negedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ob_table_arb.md
Name: ob_table_arb

Overview:
- Arbiter and sequencer for the ask-side order table's single command/response port.
- Shares the port between two requesters: requester 0 is the command ingress (insert/cancel); requester 1 is the match engine (peek/pop best).
- Issues one transaction at a time, routes each response to its owner, and times out a table that fails to answer.
- Sits between ingress/matcher and ob_ask_table.

Parameters:
- UID_W, 32, order identifier width
- PRICE_W, 16, price width
- QTY_W, 16, quantity width
- TIMEOUT, 255, consecutive WAIT cycles without table response before a TIMEOUT status is returned (legal range >= 1)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cmd0_vld  in  1  requester 0 command valid
- cmd0  in  $bits(ob_tbl_cmd_t)  requester 0 command
- cmd0_rdy  out  1  requester 0 command accepted
- cmd1_vld  in  1  requester 1 command valid
- cmd1  in  $bits(ob_tbl_cmd_t)  requester 1 command
- cmd1_rdy  out  1  requester 1 command accepted
- rsp0_vld  out  1  response to requester 0 valid
- rsp0  out  $bits(ob_tbl_rsp_t)  response to requester 0
- rsp0_rdy  in  1  requester 0 takes response
- rsp1_vld  out  1  response to requester 1 valid
- rsp1  out  $bits(ob_tbl_rsp_t)  response to requester 1
- rsp1_rdy  in  1  requester 1 takes response
- tbl_cmd_vld  out  1  command to table valid
- tbl_cmd  out  $bits(ob_tbl_cmd_t)  command to table
- tbl_cmd_rdy  in  1  table accepts command
- tbl_rsp_vld  in  1  table response valid (single-cycle pulse, no backpressure)
- tbl_rsp  in  $bits(ob_tbl_rsp_t)  table response
- busy  out  1  transaction in flight (state != IDLE)
- err_spurious  out  1  sticky: tbl_rsp_vld seen outside WAIT

Behaviour:
- Clock and reset: one clock, clk; synchronous active-high reset, rst.
- Reset values: state=IDLE, prio pointer ptr=0, all *_vld/*_rdy outputs 0, busy=0, err_spurious=0, timer=0.
- rst mid-transaction abandons it with no response; any later table response sets err_spurious.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - win = 1 if cmd1_vld && (!cmd0_vld || ptr==1); else win = 0 if cmd0_vld.
  - cmdN_rdy = 1 combinationally for the winner only.
  - On handshake: latch cmd and owner=win; go to ISSUE.
- ISSUE:
  - tbl_cmd_vld=1 and tbl_cmd = latched command, held stable until tbl_cmd_rdy.
  - On tbl_cmd_rdy: go to WAIT, timer=0.
  - No timeout in ISSUE.
- WAIT:
  - On tbl_rsp_vld: latch tbl_rsp; go to RESP.
  - Otherwise timer++. When timer reaches TIMEOUT-1 without response, latch {status=TIMEOUT, uid=cmd.uid, price=0, qty=0}; go to RESP.
  - A response arriving in the expiry cycle wins over the timeout.
- RESP:
  - rsp[owner]_vld=1 with the latched response, stable until rsp[owner]_rdy.
  - On handshake: ptr = ~owner; go to IDLE.
- Fairness: round robin. The loser of a simultaneous request is guaranteed the next grant.
- Latency:
  - Command accepted at T gives tbl_cmd_vld at T+1.
  - Table response at W gives rspN_vld at W+1.
  - Back-to-back minimum: the next command is accepted the cycle after the RESP handshake.
- tbl_rsp_vld in IDLE/ISSUE/RESP: ignored, sets err_spurious. This covers late responses after a timeout.
- Requesters may drop cmdN_vld without penalty before being granted.

Decomposition:
- Add to ob_pkg:
  - ob_tbl_op_t: 2b opcode enum, OP_INSERT=0, OP_CANCEL=1, OP_PEEK=2, OP_POP=3.
  - ob_tbl_status_t: 2b enum, ST_OK=0, ST_EMPTY=1, ST_NOTFOUND=2, ST_TIMEOUT=3.
  - ob_tbl_cmd_t: {op, uid, price, qty}.
  - ob_tbl_rsp_t: {status, uid, price, qty}.
- The same types are reused by the bid-side table.
- Sub-module ob_rr_arb2 (2-way round-robin picker: req[1:0], ptr, gnt[1:0]) is reused by the bid-side arbiter.
- Timer and FSM remain inline.

Test Plan:
- Single request: cmd0={INSERT,uid=5,price=100,qty=10}, table rdy=1 and responds ST_OK 3 cycles after acceptance -> tbl_cmd_vld 1 cycle after cmd0_rdy; rsp0_vld 1 cycle after tbl_rsp_vld with status OK, uid 5; rsp1_vld never set.
- Contention: cmd0_vld and cmd1_vld held high from reset for 4 transactions -> grant order 0,1,0,1; each response routed only to its owner.
- Backpressure: tbl_cmd_rdy=0 for 5 cycles, then rsp0_rdy=0 for 4 cycles -> tbl_cmd and rsp0 held stable throughout; no second grant while busy=1.
- Timeout: TIMEOUT=8, table never responds -> rsp1 status ST_TIMEOUT exactly 8 WAIT cycles after issue; a table response 2 cycles after RESP sets err_spurious=1 and it stays 1.
- Race: tbl_rsp_vld in the same cycle the timer expires -> table response delivered, status OK, err_spurious remains 0.
- Reset mid-WAIT: rst asserted one cycle -> next cycle busy=0, all vld=0, ptr=0; a subsequent cmd1-only request is granted normally.
